// File: rtl/imm_gen_pipe.sv
`default_nettype none
//==============================================================================
// Module      : imm_gen_pipe
// Description : Registered RISC-V immediate generator with a 2-entry skid
//               buffer on a valid/ready handshake. Optional Z-type CSR
//               immediates are enabled by defining IMM_ZTYPE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] c_TYPE_NONE = 3'd0;
    localparam logic [2:0] c_TYPE_I    = 3'd1;
    localparam logic [2:0] c_TYPE_S    = 3'd2;
    localparam logic [2:0] c_TYPE_B    = 3'd3;
    localparam logic [2:0] c_TYPE_U    = 3'd4;
    localparam logic [2:0] c_TYPE_J    = 3'd5;
    localparam logic [2:0] c_TYPE_Z    = 3'd6;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_rv64;

    generate
        if (XLEN == 64) begin : g_rv64
            assign w_rv64 = 1'b1;
        end else begin : g_rv32
            assign w_rv64 = 1'b0;
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Format classification and immediate assembly
    //--------------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic            w_sign;
    logic [2:0]      w_type;
    logic [XLEN-1:0] w_imm;
    logic            w_unused_ok;

    assign w_opcode    = in_instr[6:0];
    assign w_sign      = in_instr[31];
    assign w_unused_ok = &{1'b0, in_instr[14:12]};

    always_comb begin
        w_type = c_TYPE_NONE;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC:           w_type = c_TYPE_U;
            c_OP_JAL:                       w_type = c_TYPE_J;
            c_OP_JALR, c_OP_LOAD, c_OP_IMM: w_type = c_TYPE_I;
            c_OP_SYSTEM: begin
`ifdef IMM_ZTYPE_EN
                w_type = in_instr[14] ? c_TYPE_Z : c_TYPE_I;
`else
                w_type = c_TYPE_I;
`endif
            end
            c_OP_IMM32:                     w_type = w_rv64 ? c_TYPE_I : c_TYPE_NONE;
            c_OP_STORE:                     w_type = c_TYPE_S;
            c_OP_BRANCH:                    w_type = c_TYPE_B;
            default:                        w_type = c_TYPE_NONE;
        endcase
    end

    // Replication counts keep at least one sign bit so XLEN=32 never needs a
    // zero-width replication; bit 31 itself is supplied by the replication.
    always_comb begin
        w_imm = '0;
        case (w_type)
            c_TYPE_I: w_imm = {{(XLEN-11){w_sign}}, in_instr[30:20]};
            c_TYPE_S: w_imm = {{(XLEN-11){w_sign}}, in_instr[30:25], in_instr[11:7]};
            c_TYPE_B: w_imm = {{(XLEN-12){w_sign}}, in_instr[7], in_instr[30:25],
                               in_instr[11:8], 1'b0};
            c_TYPE_U: w_imm = {{(XLEN-31){w_sign}}, in_instr[30:12], 12'h000};
            c_TYPE_J: w_imm = {{(XLEN-20){w_sign}}, in_instr[19:12], in_instr[20],
                               in_instr[30:21], 1'b0};
            c_TYPE_Z: w_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            default:  w_imm = '0;
        endcase
    end

    //--------------------------------------------------------------------------
    // Skid-buffer control
    //--------------------------------------------------------------------------
    logic w_accept;
    logic w_drain;
    logic w_load_m_in;
    logic w_load_m_k;
    logic w_load_k;

    assign in_ready  = (r_state != S_TWO) && !rst;
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_m_in = 1'b0;
        w_load_m_k  = 1'b0;
        w_load_k    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_m_in = 1'b1;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_m_in = 1'b1;
                end else if (w_accept) begin
                    w_load_k    = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_drain) begin
                    w_load_m_k  = 1'b1;
                    w_state_nxt = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush discards both buffered entries and any entry offered this cycle.
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_load_m_in = 1'b0;
            w_load_m_k  = 1'b0;
            w_load_k    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Main (M) and skid (K) entry storage
    //--------------------------------------------------------------------------
    logic [XLEN-1:0]  r_m_imm;
    logic [2:0]       r_m_type;
    logic [TAG_W-1:0] r_m_tag;
    logic [XLEN-1:0]  r_k_imm;
    logic [2:0]       r_k_type;
    logic [TAG_W-1:0] r_k_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_imm  <= '0;
            r_m_type <= c_TYPE_NONE;
            r_m_tag  <= '0;
            r_k_imm  <= '0;
            r_k_type <= c_TYPE_NONE;
            r_k_tag  <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_imm  <= w_imm;
                r_m_type <= w_type;
                r_m_tag  <= in_tag;
            end else if (w_load_m_k) begin
                r_m_imm  <= r_k_imm;
                r_m_type <= r_k_type;
                r_m_tag  <= r_k_tag;
            end
            if (w_load_k) begin
                r_k_imm  <= w_imm;
                r_k_type <= w_type;
                r_k_tag  <= in_tag;
            end else if (w_load_m_k) begin
                r_k_imm  <= '0;
                r_k_type <= c_TYPE_NONE;
                r_k_tag  <= '0;
            end
        end
    end

    assign out_imm  = r_m_imm;
    assign out_type = r_m_type;
    assign out_tag  = r_m_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
//==============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64
//               instances in lockstep) with a scoreboard queue.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] tag;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic [31:0] out_tag;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_type64;
    logic [31:0] out_tag64;

    int  n_vec = 0;
    int  n_err = 0;
    sb_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_type(out_type), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_type(out_type64), .out_tag(out_tag64)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
        end
    endtask

    // Reference decode: returns {type, imm}; imm truncated to 32 bits for RV32.
    function automatic logic [66:0] ref_dec(input logic [31:0] ins, input bit rv64);
        logic signed [63:0] v;
        logic [2:0]         ty;
        v  = '0;
        ty = 3'd0;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin ty = 3'd4; v = $signed({ins[31:12], 12'h000}); end
            7'b1101111: begin
                ty = 3'd5;
                v  = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin ty = 3'd1; v = $signed(ins[31:20]); end
            7'b1110011: begin
`ifdef IMM_ZTYPE_EN
                if (ins[14]) begin ty = 3'd6; v = {59'd0, ins[19:15]}; end else
`endif
                begin ty = 3'd1; v = $signed(ins[31:20]); end
            end
            7'b0011011: if (rv64) begin ty = 3'd1; v = $signed(ins[31:20]); end
            7'b0100011: begin ty = 3'd2; v = $signed({ins[31:25], ins[11:7]}); end
            7'b1100011: begin
                ty = 3'd3;
                v  = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            end
            default: ;
        endcase
        if (!rv64) v[63:32] = '0;
        return {ty, v};
    endfunction

    // Scoreboard: push on accept, compare every valid cycle, pop on drain.
    always @(negedge clk) begin
        logic [66:0] r32;
        logic [66:0] r64;
        sb_t         e;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    e   = q[0];
                    r32 = ref_dec(e.instr, 1'b0);
                    r64 = ref_dec(e.instr, 1'b1);
                    chk("imm32",   {32'd0, out_imm}, r32[63:0]);
                    chk("type32",  {61'd0, out_type}, {61'd0, r32[66:64]});
                    chk("tag32",   {32'd0, out_tag}, {32'd0, e.tag});
                    chk("valid64", {63'd0, out_valid64}, 64'd1);
                    chk("imm64",   out_imm64, r64[63:0]);
                    chk("type64",  {61'd0, out_type64}, {61'd0, r64[66:64]});
                    chk("tag64",   {32'd0, out_tag64}, {32'd0, e.tag});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back('{instr: in_instr, tag: in_tag});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] tg);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tg;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                chk("send_timeout", {63'd0, in_ready}, 64'd1);
                break;
            end
            @(negedge clk);
        end
        tick();
    endtask

    task automatic wait_empty;
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        tick();
    endtask

    logic [6:0] ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b0000011, 7'b0010011, 7'b1110011, 7'b0011011,
                             7'b0100011, 7'b1100011, 7'b0110011, 7'b1111111};

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_imm",     {32'd0, out_imm}, 64'd0);
        chk("rst_type",    {61'd0, out_type}, 64'd0);
        chk("rst_tag",     {32'd0, out_tag}, 64'd0);
        chk("post_ready",  {63'd0, in_ready}, 64'd1);
        chk("post_ready64", {63'd0, in_ready64}, 64'd1);

        // Single-cycle latency, addi x1,x0,-1
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_tag    = 32'h0000_1000;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_type",  {61'd0, out_type}, 64'd1);
        chk("lat_imm",   {32'd0, out_imm}, 64'h0000_0000_FFFF_FFFF);
        tick();
        @(negedge clk);
        chk("lat_gone", {63'd0, out_valid}, 64'd0);

        // Back-to-back stream including RV64 U-type sign extension
        tick();
        send(32'hFE20AC23, 32'h100);
        send(32'h123450B7, 32'h104);
        send(32'h800000B7, 32'h108);
        send(32'h0040009B, 32'h10C);
        in_valid = 1'b0;
        wait_empty();

        // Back-pressure: fill both entries, hold a third
        out_ready = 1'b0;
        send(32'hFFDFF06F, 32'h200);
        send(32'hFE20AC23, 32'h204);
        in_instr = 32'h00500113;
        in_tag   = 32'h208;
        @(negedge clk);
        chk("bp_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_hold", {63'd0, in_ready}, 64'd0);
            chk("bp_imm_hold",   {32'd0, out_imm}, 64'h0000_0000_FFFF_FFFC);
        end
        tick();
        out_ready = 1'b1;
        send(32'h00500113, 32'h208);
        in_valid = 1'b0;
        wait_empty();

        // Flush in TWO with a simultaneous offer
        out_ready = 1'b0;
        send(32'h00A00093, 32'h300);
        send(32'h00B00093, 32'h304);
        in_instr = 32'h00C00093;
        in_tag   = 32'h308;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        tick();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_quiet", {63'd0, out_valid}, 64'd0);
        end

        // Flush overrides an accept while EMPTY
        tick();
        in_valid = 1'b1;
        in_instr = 32'h00D00093;
        in_tag   = 32'h30C;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_acc_valid", {63'd0, out_valid}, 64'd0);

        // Reset mid-transfer
        tick();
        out_ready = 1'b0;
        send(32'h00E00093, 32'h400);
        send(32'h00F00093, 32'h404);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_tag",   {32'd0, out_tag}, 64'd0);

        // Unknown opcode still passes with its tag
        tick();
        out_ready = 1'b1;
        send(32'h0000007F, 32'h55);
        in_valid = 1'b0;
        @(negedge clk);
        chk("unk_valid", {63'd0, out_valid}, 64'd1);
        chk("unk_type",  {61'd0, out_type}, 64'd0);
        chk("unk_imm",   {32'd0, out_imm}, 64'd0);
        chk("unk_tag",   {32'd0, out_tag}, 64'h55);

        // csrrwi x0,0x300,31
        tick();
        send(32'h300FD073, 32'h66);
        in_valid = 1'b0;
        @(negedge clk);
`ifdef IMM_ZTYPE_EN
        chk("csr_type", {61'd0, out_type}, 64'd6);
        chk("csr_imm",  {32'd0, out_imm}, 64'h1F);
`else
        chk("csr_type", {61'd0, out_type}, 64'd1);
        chk("csr_imm",  {32'd0, out_imm}, 64'h300);
`endif
        tick();

        // Random stream under random back-pressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] ins;
                    ins      = $urandom;
                    ins[6:0] = ops[$urandom_range(0, 11)];
                    send(ins, 32'h1000 + 32'(i));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (300) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
